// File: rtl/gcn_fetch_scheduler.sv
// rtl/gcn_fetch_scheduler.sv - GCN top-level fetch/MAC/aggregation sequencer
module gcn_fetch_scheduler #(
    parameter int FEATURE_ROWS          = 6,
    parameter int WEIGHT_COLS           = 3,
    parameter int ADDRESS_WIDTH         = 13,
    parameter int FEATURE_BASE          = 512,
    parameter int COO_NUM_OF_COLS       = 6,
    parameter int COO_BW                = $clog2(COO_NUM_OF_COLS),
    parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS),
    parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             mac_done,
    output logic                             enable_read,
    output logic [ADDRESS_WIDTH-1:0]         read_address,
    output logic                             weight_load,
    output logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_col_idx,
    output logic                             feature_load,
    output logic [COUNTER_FEATURE_WIDTH-1:0] feature_row_idx,
    output logic                             mac_start,
    output logic [COO_BW-1:0]                coo_address,
    output logic                             agg_valid,
    output logic                             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_F,
        S_MAC_START,
        S_MAC_WAIT,
        S_COMBINE,
        S_DONE
    } state_t;

    localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  W_LAST = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);
    localparam logic [COUNTER_FEATURE_WIDTH-1:0] F_LAST = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [COO_BW-1:0]                C_LAST = COO_BW'(COO_NUM_OF_COLS - 1);
    localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  W_ONE  = COUNTER_WEIGHT_WIDTH'(1);
    localparam logic [COUNTER_FEATURE_WIDTH-1:0] F_ONE  = COUNTER_FEATURE_WIDTH'(1);
    localparam logic [COO_BW-1:0]                C_ONE  = COO_BW'(1);
    localparam logic [ADDRESS_WIDTH-1:0]         F_BASE = ADDRESS_WIDTH'(FEATURE_BASE);

    state_t                             r_state;
    state_t                             w_state_nxt;
    logic [COUNTER_WEIGHT_WIDTH-1:0]    r_w_cnt;
    logic [COUNTER_WEIGHT_WIDTH-1:0]    w_w_cnt_nxt;
    logic [COUNTER_FEATURE_WIDTH-1:0]   r_f_cnt;
    logic [COUNTER_FEATURE_WIDTH-1:0]   w_f_cnt_nxt;
    logic [COO_BW-1:0]                  r_c_cnt;
    logic [COO_BW-1:0]                  w_c_cnt_nxt;

    // State and counter registers; reset drops everything to IDLE at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_w_cnt <= '0;
            r_f_cnt <= '0;
            r_c_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_w_cnt <= w_w_cnt_nxt;
            r_f_cnt <= w_f_cnt_nxt;
            r_c_cnt <= w_c_cnt_nxt;
        end
    end

    // Next-state/counter logic; outputs decode only registered state and counters.
    always_comb begin
        w_state_nxt     = r_state;
        w_w_cnt_nxt     = r_w_cnt;
        w_f_cnt_nxt     = r_f_cnt;
        w_c_cnt_nxt     = r_c_cnt;
        enable_read     = 1'b0;
        read_address    = '0;
        weight_load     = 1'b0;
        weight_col_idx  = '0;
        feature_load    = 1'b0;
        feature_row_idx = '0;
        mac_start       = 1'b0;
        coo_address     = '0;
        agg_valid       = 1'b0;
        done            = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD_W;
                    w_w_cnt_nxt = '0;
                end
            end
            S_LOAD_W: begin
                enable_read    = 1'b1;
                read_address   = ADDRESS_WIDTH'(r_w_cnt);
                weight_load    = 1'b1;
                weight_col_idx = r_w_cnt;
                if (r_w_cnt == W_LAST) begin
                    w_state_nxt = S_LOAD_F;
                    w_f_cnt_nxt = '0;
                end else begin
                    w_w_cnt_nxt = r_w_cnt + W_ONE;
                end
            end
            S_LOAD_F: begin
                enable_read     = 1'b1;
                read_address    = F_BASE + ADDRESS_WIDTH'(r_f_cnt);
                feature_load    = 1'b1;
                feature_row_idx = r_f_cnt;
                w_state_nxt     = S_MAC_START;
            end
            S_MAC_START: begin
                mac_start       = 1'b1;
                feature_row_idx = r_f_cnt;
                w_state_nxt     = S_MAC_WAIT;
            end
            S_MAC_WAIT: begin
                feature_row_idx = r_f_cnt;
                if (mac_done) begin
                    if (r_f_cnt == F_LAST) begin
                        w_state_nxt = S_COMBINE;
                        w_c_cnt_nxt = '0;
                    end else begin
                        w_f_cnt_nxt = r_f_cnt + F_ONE;
                        w_state_nxt = S_LOAD_F;
                    end
                end
            end
            S_COMBINE: begin
                coo_address = r_c_cnt;
                agg_valid   = 1'b1;
                if (r_c_cnt == C_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_c_cnt_nxt = r_c_cnt + C_ONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gcn_fetch_scheduler.sv
// tb/tb_gcn_fetch_scheduler.sv - scoreboard bench for gcn_fetch_scheduler
module tb_gcn_fetch_scheduler;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mac_done;
    logic        enable_read;
    logic [12:0] read_address;
    logic        weight_load;
    logic [1:0]  weight_col_idx;
    logic        feature_load;
    logic [2:0]  feature_row_idx;
    logic        mac_start;
    logic [2:0]  coo_address;
    logic        agg_valid;
    logic        done;

    gcn_fetch_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .mac_done        (mac_done),
        .enable_read     (enable_read),
        .read_address    (read_address),
        .weight_load     (weight_load),
        .weight_col_idx  (weight_col_idx),
        .feature_load    (feature_load),
        .feature_row_idx (feature_row_idx),
        .mac_start       (mac_start),
        .coo_address     (coo_address),
        .agg_valid       (agg_valid),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] addr;
        logic        wl;
        logic [2:0]  idx;
    } rd_t;

    rd_t  rdq[$];
    int   macq[$];
    int   cooq[$];
    int   doneq[$];

    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    int   mac_mode = 0;
    int   wcnt     = 0;
    int   last_row = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s got=event exp=none", name);
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Scoreboard monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        rd_t e;
        int  v;
        if (enable_read) begin
            if (rdq.size() == 0) flag("read_unexpected");
            else begin
                e = rdq.pop_front();
                if (e.wl)
                    check("weight_read", {read_address, weight_load, feature_load, 1'b0, weight_col_idx},
                          {e.addr, 1'b1, 1'b0, 1'b0, e.idx[1:0]});
                else
                    check("feature_read", {read_address, weight_load, feature_load, feature_row_idx},
                          {e.addr, 1'b0, 1'b1, e.idx});
            end
        end
        if (mac_start) begin
            if (macq.size() == 0) flag("mac_start_unexpected");
            else begin
                v = macq.pop_front();
                last_row = v;
                check("mac_start_row", {29'd0, feature_row_idx}, v);
            end
        end
        if (agg_valid) begin
            if (cooq.size() == 0) flag("agg_unexpected");
            else begin
                v = cooq.pop_front();
                check("coo_address", {29'd0, coo_address}, v);
            end
        end
        if (done && !prev_done) begin
            if (doneq.size() == 0) flag("done_unexpected");
            else begin
                v = doneq.pop_front();
                check("done_edge", edge_cnt, v);
            end
        end
        prev_done = done;
    end

    // MAC responder: mac_done either tied high or returned k cycles after mac_start.
    always @(negedge clk) begin
        if (mac_mode == 0) begin
            mac_done = 1'b1;
            wcnt = 0;
        end else begin
            if (mac_start) wcnt = mac_mode + 1;
            else if (wcnt > 0) begin
                wcnt--;
                if (wcnt > 0)
                    check("mac_wait_hold", {enable_read, mac_start, feature_row_idx},
                          {1'b0, 1'b0, 3'(last_row)});
            end
            mac_done = (wcnt == 1);
        end
    end

    task automatic push_run(input int k, input int start_edge);
        int exp_addr [9] = '{0, 1, 2, 512, 513, 514, 515, 516, 517};
        rd_t e;
        for (int i = 0; i < 9; i++) begin
            e.addr = 13'(exp_addr[i]);
            e.wl   = (i < 3);
            e.idx  = (i < 3) ? 3'(i) : 3'(i - 3);
            rdq.push_back(e);
        end
        for (int i = 0; i < 6; i++) begin
            macq.push_back(i);
            cooq.push_back(i);
        end
        doneq.push_back(start_edge + 3 + 6 * (2 + k) + 6);
    endtask

    task automatic issue(input int k, input bit pulse);
        @(negedge clk);
        push_run(k, edge_cnt + 1);
        start = 1'b1;
        if (pulse) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got=0 exp=1");
        end
    endtask

    task automatic check_drained(input string name);
        check(name, rdq.size() + macq.size() + cooq.size() + doneq.size(), 0);
    endtask

    task automatic finish_run();
        wait_done();
        check("done_high", done, 1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("done_cleared", done, 0);
        check_drained("run_drained");
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        start    = 1'b0;
        mac_done = 1'b1;
        #1;
        check("reset_outputs", {enable_read, read_address, weight_load, weight_col_idx, feature_load,
                                feature_row_idx, mac_start, coo_address, agg_valid, done}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // mac_done tied high: also covers mac_done high through LOAD_W/LOAD_F/MAC_START
        mac_mode = 0;
        issue(1, 0);
        finish_run();

        // mac_done returned 5 cycles after each mac_start
        mac_mode = 5;
        issue(5, 0);
        finish_run();
        mac_mode = 0;

        // asynchronous reset in the middle of COMBINE
        issue(1, 0);
        n = 0;
        while (!agg_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_combine", agg_valid, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {enable_read, read_address, weight_load, weight_col_idx, feature_load,
                                      feature_row_idx, mac_start, coo_address, agg_valid, done}, 0);
        rdq.delete();
        macq.delete();
        cooq.delete();
        doneq.delete();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        issue(1, 0);
        finish_run();

        // start held after done: done sticks, no reads, then clean second run
        issue(1, 0);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("done_hold", {done, enable_read}, 2'b10);
        end
        start = 1'b0;
        @(negedge clk);
        check("done_drop", done, 0);
        check_drained("hold_drained");
        issue(1, 0);
        finish_run();

        // single-cycle start pulse
        issue(1, 1);
        wait_done();
        check("pulse_done", done, 1);
        @(negedge clk);
        check("pulse_done_one_cycle", done, 0);
        check_drained("pulse_drained");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gcn_fetch_scheduler.md
Name: gcn_fetch_scheduler

Overview:
- Top-level sequencer for the GCN accelerator datapath.
- Issues ordered reads to the shared weight/feature memory port, strobes the weight and feature buffers, and hands each feature row to the transformation MAC array with a start/done handshake.
- Walks the COO adjacency columns for the aggregation stage, then raises done.
- Sits between the GCN top-level ports (read_address, enable_read, coo_address, done) and the internal transformation/aggregation units.

Parameters:
- FEATURE_ROWS, 6, number of feature rows (graph nodes)
- WEIGHT_COLS, 3, number of weight columns
- ADDRESS_WIDTH, 13, memory read address width
- FEATURE_BASE, 512, memory address of feature row 0; weight column c is at address c
- COO_NUM_OF_COLS, 6, number of COO edge columns
- COO_BW, $clog2(COO_NUM_OF_COLS), COO column address width
- COUNTER_WEIGHT_WIDTH, $clog2(WEIGHT_COLS), weight index width
- COUNTER_FEATURE_WIDTH, $clog2(FEATURE_ROWS), feature index width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  level run request
- mac_done  in  1  MAC array finished the current feature row
- enable_read  out  1  memory read strobe
- read_address  out  ADDRESS_WIDTH  memory read address
- weight_load  out  1  weight buffer captures data_in
- weight_col_idx  out  COUNTER_WEIGHT_WIDTH  weight buffer slot
- feature_load  out  1  feature buffer captures data_in
- feature_row_idx  out  COUNTER_FEATURE_WIDTH  current feature row
- mac_start  out  1  one-cycle pulse; MAC begins the current row
- coo_address  out  COO_BW  COO column being presented
- agg_valid  out  1  aggregation unit consumes coo_in this cycle
- done  out  1  all computation complete

Behaviour:
- Reset (async, any state): state=IDLE, all counters=0, every output=0.
- Outputs are decoded from registered state and counters only; there is no combinational input-to-output path.
- Memory/COO timing: address is driven during cycle N, data is valid before the rising edge that closes cycle N. Consumers sample data_in/coo_in at that edge while the matching load/valid strobe is high.
- IDLE: all outputs 0. Goes to LOAD_W when start=1 is sampled, with w_cnt=0.
- LOAD_W:
  - Outputs: enable_read=1, read_address=w_cnt, weight_load=1, weight_col_idx=w_cnt.
  - If w_cnt==WEIGHT_COLS-1: go to LOAD_F with f_cnt=0. Otherwise w_cnt++.
  - Takes exactly WEIGHT_COLS cycles.
- LOAD_F: enable_read=1, read_address=FEATURE_BASE+f_cnt, feature_load=1, feature_row_idx=f_cnt. Goes to MAC_START next cycle.
- MAC_START: mac_start=1 and feature_row_idx=f_cnt for one cycle. Goes to MAC_WAIT.
- MAC_WAIT:
  - feature_row_idx=f_cnt; enable_read=0.
  - On mac_done=1: if f_cnt==FEATURE_ROWS-1, go to COMBINE with c_cnt=0. Otherwise f_cnt++ and go to LOAD_F.
  - Holds indefinitely while mac_done=0.
- COMBINE:
  - Outputs: coo_address=c_cnt, agg_valid=1.
  - If c_cnt==COO_NUM_OF_COLS-1: go to DONE. Otherwise c_cnt++.
  - Takes exactly COO_NUM_OF_COLS cycles.
- DONE: done=1 and all other strobes 0. Returns to IDLE when start=0. Stays in DONE while start remains 1; there is no auto-restart.
- mac_done is ignored in every state except MAC_WAIT, including a mac_done asserted during MAC_START.
- start is ignored outside IDLE and DONE; deasserting start mid-run does not abort the run.
- Counters never wrap: each counter stops at its terminal value and is cleared on state entry.
- read_address arithmetic is unsigned, ADDRESS_WIDTH bits. FEATURE_BASE+FEATURE_ROWS-1 must fit (511 < FEATURE_BASE ≤ 2^13-FEATURE_ROWS).
- Latency: with mac_done returned k cycles after mac_start, start-sample edge to done=1 is WEIGHT_COLS + FEATURE_ROWS*(2+k) + COO_NUM_OF_COLS edges. With defaults and k=1 that is 27 edges.

Test Plan:
- Reset, then start=1, with mac_done tied 1 → read_address sequence 0,1,2,512,513,514,515,516,517.
  - weight_load for 3 cycles, feature_load 6 single pulses, mac_start 6 pulses.
  - coo_address 0..5 with agg_valid=1.
  - done rises exactly 27 rising edges after the start-sample edge.
- mac_done asserted 5 cycles after each mac_start → FSM holds in MAC_WAIT with enable_read=0 and feature_row_idx stable. done rises at edge 3+6*7+6=51.
- mac_done held high during LOAD_W, LOAD_F and MAC_START → no state skipped; pulse counts identical to the first scenario.
- Assert reset asynchronously mid-COMBINE (between edges) → all outputs 0 immediately, before the next edge. After release, start=1 reruns the full sequence from read_address=0.
- Hold start=1 after done → done stays 1 and no further enable_read. Drop start → done=0 next edge. Raise start again → second identical run.
- start pulsed high for one cycle only → full run completes; done=1 for one cycle, then return to IDLE because start=0.
